// File: rtl/vip_frame_stream_gen.sv
// Video timing and Y pixel stream source for the VIP pipeline.
// Optional `VIP_STREAM_TPG_EN swaps the FIFO for an internal ramp pattern.
module vip_frame_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45,
  parameter int VS_LINES = 2,
  parameter int CLK_DIV  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       src_empty,
  input  logic [7:0] src_data,
  output logic       src_rd_req,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_y,
  output logic       frame_done,
  output logic       underflow
);

  localparam int H_TOT = H_ACTIVE + H_BLANK;
  localparam int V_TOT = V_BLANK + V_ACTIVE;
  localparam int HW = (H_TOT > 1) ? $clog2(H_TOT) : 1;
  localparam int VW = (V_TOT > 1) ? $clog2(V_TOT) : 1;

  localparam logic [HW-1:0] H_MAX = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_MAX = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_BL  = VW'(V_BLANK);
  localparam logic [VW-1:0] VS_L  = VW'(VS_LINES);
  localparam logic [1:0]    D_MAX = 2'(CLK_DIV - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic [1:0]    d;
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  logic       run;
  logic       d_last;
  logic       h_last;
  logic       v_last;
  logic       frame_last;
  logic       frame_start;
  logic       vsync_n;
  logic       href_n;
  logic       clken_n;
  logic       under_set;
  logic [7:0] y_next;

  assign run        = (state == S_RUN);
  assign d_last     = (d == D_MAX);
  assign h_last     = (h == H_MAX);
  assign v_last     = (v == V_MAX);
  assign frame_last = run & d_last & h_last & v_last;

  // Counters land on (0,0,0) from IDLE or on a frame wrap.
  assign frame_start = enable & (~run | frame_last);

  assign vsync_n = run & (v < VS_L);
  assign href_n  = run & (v >= V_BL) & (h < H_ACT);
  assign clken_n = href_n & (d == 2'd0);

`ifdef VIP_STREAM_TPG_EN
  logic unused_src;
  assign unused_src = ^{src_empty, src_data};
  assign src_rd_req = 1'b0;
  assign under_set  = 1'b0;
  assign y_next     = clken_n ?
                      (8'(h) + 8'(v) - 8'(V_BLANK)) :
                      8'd0;
`else
  // Pop only when a slot needs a pixel and one is there.
  assign src_rd_req = clken_n & ~src_empty;
  assign under_set  = clken_n & src_empty;
  assign y_next     = src_rd_req ? src_data : 8'd0;
`endif

  // Run/idle control and the d/h/v slot counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      d     <= '0;
      h     <= '0;
      v     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          d <= '0;
          h <= '0;
          v <= '0;
          if (enable) state <= S_RUN;
        end
        default: begin
          if (frame_last) begin
            d <= '0;
            h <= '0;
            v <= '0;
            if (!enable) state <= S_IDLE;
          end else if (d_last) begin
            d <= '0;
            if (h_last) begin
              h <= '0;
              v <= v + 1'b1;
            end else begin
              h <= h + 1'b1;
            end
          end else begin
            d <= d + 1'b1;
          end
        end
      endcase
    end
  end

  // Registered stream outputs, one cycle behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_y       <= 8'd0;
      frame_done       <= 1'b0;
    end else begin
      post_frame_vsync <= vsync_n;
      post_frame_href  <= href_n;
      post_frame_clken <= clken_n;
      post_img_y       <= y_next;
      frame_done       <= frame_last;
    end
  end

  // Sticky underflow, cleared whenever a new frame begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (frame_start) begin
      underflow <= 1'b0;
    end else if (under_set) begin
      underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vip_frame_stream_gen.sv
// Directed bench for vip_frame_stream_gen.
// Two instances: CLK_DIV=1 and CLK_DIV=3, 4x3 active, 2/2 blanking.
module tb_vip_frame_stream_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       e1 = 1'b0;
  logic       e3 = 1'b0;
  logic       force1 = 1'b0;
  logic       emp1, emp3, rd1, rd3;
  logic [7:0] dat1, dat3;
  logic       vs1, hr1, ck1, dn1, uf1;
  logic       vs3, hr3, ck3, dn3, uf3;
  logic [7:0] y1, y3;

  logic [7:0] mem [0:127];
  int rp1 = 0;
  int rp3 = 0;

  assign dat1 = mem[rp1[6:0]];
  assign dat3 = mem[rp3[6:0]];
  assign emp1 = force1 | (rp1 >= 64);
  assign emp3 = (rp3 >= 64);

  always @(posedge clk) begin
    if (rd1) rp1 <= rp1 + 1;
    if (rd3) rp3 <= rp3 + 1;
  end

  vip_frame_stream_gen #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3),
    .V_BLANK(2), .VS_LINES(1), .CLK_DIV(1)
  ) u_div1 (
    .clk(clk), .rst_n(rst_n), .enable(e1),
    .src_empty(emp1), .src_data(dat1),
    .src_rd_req(rd1),
    .post_frame_vsync(vs1), .post_frame_href(hr1),
    .post_frame_clken(ck1), .post_img_y(y1),
    .frame_done(dn1), .underflow(uf1)
  );

  vip_frame_stream_gen #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3),
    .V_BLANK(2), .VS_LINES(1), .CLK_DIV(3)
  ) u_div3 (
    .clk(clk), .rst_n(rst_n), .enable(e3),
    .src_empty(emp3), .src_data(dat3),
    .src_rd_req(rd3),
    .post_frame_vsync(vs3), .post_frame_href(hr3),
    .post_frame_clken(ck3), .post_img_y(y3),
    .frame_done(dn3), .underflow(uf3)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
  endtask

  // Expected-state model: run flag, flat cycle index in frame,
  // pixels popped so far, underflow flag.
  int   r_m [2] = '{0, 0};
  int   t_m [2] = '{0, 0};
  int   m_m [2] = '{0, 0};
  logic u_m [2] = '{1'b0, 1'b0};

  function automatic logic [12:0] got_vec(input int k);
    if (k == 0) return {vs1, hr1, ck1, dn1, uf1, y1};
    return {vs3, hr3, ck3, dn3, uf3, y3};
  endfunction

  task automatic cycle(input logic en1, input logic en3,
                       input logic bad);
    logic erd [2];
    e1 = en1;
    e3 = en3;
    force1 = bad;
    #1;
    for (int k = 0; k < 2; k++) begin
      int dv = (k == 0) ? 1 : 3;
      int s  = t_m[k] / dv;
      logic sl = (r_m[k] != 0) && (s / 6 >= 2) &&
                 (s % 6 < 4) && (t_m[k] % dv == 0);
`ifdef VIP_STREAM_TPG_EN
      erd[k] = 1'b0;
      if (sl) begin end
`else
      erd[k] = sl && !((k == 0) && force1);
`endif
    end
    chk("rd1", {31'd0, rd1}, {31'd0, erd[0]});
    chk("rd3", {31'd0, rd3}, {31'd0, erd[1]});
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      int dv   = (k == 0) ? 1 : 3;
      int last = 30 * dv - 1;
      int s    = t_m[k] / dv;
      int hh   = s % 6;
      int vv   = s / 6;
      logic rn = (r_m[k] != 0);
      logic en = (k == 0) ? en1 : en3;
      logic fe = (k == 0) && force1;
      logic ev = rn && (vv < 1);
      logic eh = rn && (vv >= 2) && (hh < 4);
      logic ec = eh && (t_m[k] % dv == 0);
      logic ed = rn && (t_m[k] == last);
      logic [7:0] ey;
`ifdef VIP_STREAM_TPG_EN
      ey = ec ? 8'(hh + vv - 2) : 8'd0;
      if (fe) begin end
`else
      ey = erd[k] ? 8'(m_m[k] + 1) : 8'd0;
      if (erd[k]) m_m[k]++;
      if (ec && fe) u_m[k] = 1'b1;
`endif
      if (!rn) begin
        if (en) begin
          r_m[k] = 1; t_m[k] = 0; u_m[k] = 1'b0;
        end
      end else if (t_m[k] == last) begin
        t_m[k] = 0;
        if (en) u_m[k] = 1'b0;
        else r_m[k] = 0;
      end else begin
        t_m[k]++;
      end
      chk(k == 0 ? "out_div1" : "out_div3",
          {19'd0, got_vec(k)},
          {19'd0, ev, eh, ec, ed, u_m[k], ey});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_d1"}, {19'd0, got_vec(0)}, 32'd0);
    chk({tag, "_d3"}, {19'd0, got_vec(1)}, 32'd0);
    chk({tag, "_rd"}, {30'd0, rd1, rd3}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i + 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_uf", {30'd0, uf1, uf3}, 32'd0);
    rst_n = 1'b1;

    // Three div1 frames: clean, underflow on pixel 6, enable
    // dropped at cycle 10 of the third. One div3 frame.
    for (int i = 0; i < 96; i++)
      cycle(i < 71, i < 40, i == 50);
    chk_zero("idle1");
    chk("pops1", rp1, m_m[0]);
    chk("pops3", rp3, m_m[1]);

    // Restart, then async reset while div1 is in href.
    for (int i = 0; i < 15; i++)
      cycle(1'b1, 1'b1, 1'b0);
    chk("pre_rst_href", {31'd0, hr1}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    chk("mid_rst_uf", {30'd0, uf1, uf3}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      r_m[k] = 0; t_m[k] = 0; u_m[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_zero("held_rst");
    rst_n = 1'b1;

    // Fresh frame from v=0 after reset release.
    for (int i = 0; i < 93; i++)
      cycle(i < 10, i < 10, 1'b0);
    chk_zero("idle2");
    chk("pops1_end", rp1, m_m[0]);
    chk("pops3_end", rp3, m_m[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vip_frame_stream_gen.md
# vip_frame_stream_gen

Video timing and pixel stream source for the VIP pipeline. It produces the `per_frame_vsync` / `per_frame_href` / `per_frame_clken` / 8-bit Y stream that the 3x3 matrix generator and Sobel stages consume. Pixels are pulled from an upstream show-ahead FIFO, such as the SDRAM read FIFO. Output frames have programmable active size, blanking and pixel pacing, and frames start and stop only on frame boundaries.

## Interface
Parameters:
- `H_ACTIVE`, default 640: active pixel slots per line.
- `H_BLANK`, default 160: blank slots per line. Must be ≥1.
- `V_ACTIVE`, default 480: active lines per frame.
- `V_BLANK`, default 45: blank lines, placed before the active lines. Must be ≥ `VS_LINES`.
- `VS_LINES`, default 2: lines with vsync high, starting at frame line 0.
- `CLK_DIV`, default 1: clk cycles per pixel slot. Range 1–4.

Ports:
- `clk` input 1: system clock. The block has one clock; reset is asynchronous and active-low.
- `rst_n` input 1: asynchronous active-low reset.
- `enable` input 1: run request. It is level-sensitive and honoured only at frame boundaries.
- `src_empty` input 1: upstream FIFO empty.
- `src_data` input 8: upstream FIFO show-ahead data.
- `src_rd_req` output 1: FIFO pop. It is combinational.
- `post_frame_vsync` output 1: frame sync, active high.
- `post_frame_href` output 1: active-line window.
- `post_frame_clken` output 1: pixel strobe, one cycle per slot.
- `post_img_y` output 8: pixel value. It is valid only while `post_frame_clken` is high.
- `frame_done` output 1: one-cycle pulse on the last slot of a frame.
- `underflow` output 1: sticky flag. It is set when the FIFO was empty on a required pop, and cleared at the next frame start.

## Operation
- State machine:
  - IDLE: counters are held at 0. All stream outputs are 0.
  - RUN: counters advance.
  - IDLE→RUN: when `enable` is sampled high. Counters start at line v=0, slot h=0, div d=0.
- Counters:
  - d counts 0..CLK_DIV-1.
  - h advances when d wraps, counting 0..H_ACTIVE+H_BLANK-1.
  - v advances when h wraps, counting 0..V_BLANK+V_ACTIVE-1.
- End of frame: at the last cycle of the frame (v, h and d all at max):
  - If `enable` is high, the counters wrap to (0,0,0) and RUN continues.
  - Otherwise the state goes to IDLE.
  - Deasserting `enable` mid-frame never truncates the frame.
- Signal decode in RUN, computed from the current counters:
  - vsync = (v < VS_LINES).
  - href = (v ≥ V_BLANK) and (h < H_ACTIVE). It is held for all CLK_DIV cycles of each slot.
  - clken = href and (d == 0).
- `src_rd_req` = clken_next and !src_empty, where clken_next is the clken decode of the current counters.
- Pixel capture: `post_img_y` registers `src_data` when the pop occurs.
- Underflow: if clken_next is high and `src_empty` is high:
  - No pop is issued.
  - `post_img_y` is 0 for that slot.
  - `underflow` is set.
  - The stream timing is not stalled.
- `underflow` is cleared on the cycle the counters enter (0,0,0), whether from IDLE or from a wrap.
- `frame_done` is asserted together with the outputs of the last frame cycle.

## Timing
- Reset: state is IDLE and counters are 0. All outputs are 0: `post_frame_vsync`, `post_frame_href`, `post_frame_clken`, `post_img_y`, `frame_done` and `underflow`. `src_rd_req` is 0.
- `src_rd_req` is 0 whenever the state is IDLE.
- All outputs except `src_rd_req` are registered. They reflect the counter state with a 1-cycle latency.
- `enable` sampled high at edge N: the state is RUN after N, and `post_frame_vsync` goes high after edge N+1.
- `src_rd_req` and the `post_img_y` capture fall on the same edge. The FIFO must present valid show-ahead data in the cycle of the request.
- Frame length is CLK_DIV × (H_ACTIVE+H_BLANK) × (V_BLANK+V_ACTIVE) cycles.
- Back-to-back frames have no gap cycle.
- Reset asserted mid-frame clears everything asynchronously. Restart then requires `enable` to be sampled again.

## Configuration
- `VIP_STREAM_TPG_EN` defined:
  - An internal test pattern replaces the FIFO: `post_img_y` = (h + (v − V_BLANK))[7:0] on each clken.
  - `src_rd_req` is tied to 0.
  - `src_empty` and `src_data` are ignored.
  - `underflow` stays 0.
- `VIP_STREAM_TPG_EN` not defined: the FIFO-sourced behaviour described above.

## Test plan
All scenarios use H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=2, VS_LINES=1, CLK_DIV=1 unless stated. Frame = 30 cycles.

- Reset then `enable`=1 with the FIFO preloaded 1..12:
  - vsync is high for 6 cycles from edge N+1.
  - First href is 12 cycles after vsync rises.
  - Three href bursts of 4 clken each carry Y=1..12.
  - `frame_done` is a single pulse in cycle 30.
  - 12 pops in total.
- Same as above with CLK_DIV=3:
  - href is held 12 cycles per line.
  - clken fires every 3rd cycle.
  - Frame = 90 cycles.
  - Pixels 1..12 unchanged.
- FIFO empty during pixel 6:
  - No pop for that slot.
  - Y=0 on that slot; all other slots' timing is unchanged.
  - `underflow` is 1 until the next frame's first cycle, then 0.
- `enable` dropped at cycle 10:
  - The frame completes all 30 cycles and `frame_done` pulses.
  - Then IDLE with all outputs 0.
  - `enable` held high instead: the next vsync follows immediately with no gap.
- `rst_n` low at cycle 17, mid-href:
  - All outputs are 0 immediately.
  - After release with `enable`=1, a full fresh frame starts from v=0.
- Build with `VIP_STREAM_TPG_EN`:
  - Line 0 Y=0,1,2,3; line 2 Y=2,3,4,5.
  - `src_rd_req` is never high.
  - `underflow` stays 0 with `src_empty`=1.
